// File: rtl/pspi_arbiter.sv
// Round-robin arbiter sharing a single PSPI host port among N_REQ requesters.
// Define PSPI_ARB_TIMEOUT_EN to enable the BUSY-phase watchdog (req_err/host_rst).
module pspi_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_rd,
    input  logic [N_REQ-1:0]      req_we,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_d,
    output logic [N_REQ-1:0]      req_ack,
    output logic [31:0]           req_rdata,
    output logic                  req_err,
    output logic [31:0]           host_a,
    output logic [31:0]           host_d,
    output logic                  host_rd,
    output logic                  host_we,
    input  logic [31:0]           host_spo,
    input  logic                  host_ready,
    output logic                  host_rst
);

    localparam int unsigned GW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    last_grant_q, grant_q;
    logic [GW-1:0]    pick;
    logic             pick_valid;
    logic             grant;
    logic             op_we_q;
    logic [31:0]      host_a_q, host_d_q, rdata_q;
    logic             timeout;
    logic [N_REQ-1:0] req_any;

    assign req_any = req_rd | req_we;
    assign grant   = (state_q == StIdle) && pick_valid && host_ready;

    // First requester strictly after last_grant, wrapping N_REQ-1 -> 0.
    always_comb begin
        logic [GW-1:0] idx;
        pick       = '0;
        pick_valid = 1'b0;
        idx        = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = GW'((32'(last_grant_q) + k) % N_REQ);
            if (!pick_valid && req_any[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

`ifdef PSPI_ARB_TIMEOUT_EN
    localparam int unsigned WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WW-1:0] wdog_q;
    logic          err_q;

    assign timeout = (state_q == StBusy) && !host_ready &&
                     (wdog_q == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
        end else if (state_q == StIssue) begin
            wdog_q <= '0;
        end else if (state_q == StBusy) begin
            wdog_q <= wdog_q + WW'(1);
        end
    end

    // Error flag lives only for the DONE cycle that follows a timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end else if (state_q == StDone) begin
            err_q <= 1'b0;
        end
    end

    assign req_err = err_q;
`else
    assign timeout = 1'b0;
    assign req_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = StIssue;
            StIssue: state_d = StBusy;
            StBusy:  if (host_ready || timeout) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Transaction datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GW'(N_REQ - 1);
            grant_q      <= '0;
            op_we_q      <= 1'b0;
            host_a_q     <= '0;
            host_d_q     <= '0;
            rdata_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        grant_q  <= pick;
                        op_we_q  <= req_we[pick];
                        host_a_q <= req_a[32*pick +: 32];
                        host_d_q <= req_d[32*pick +: 32];
                    end
                end
                StBusy: begin
                    if (host_ready) begin
                        if (!op_we_q) rdata_q <= host_spo;
                    end else if (timeout) begin
                        rdata_q <= 32'hFFFF_FFFF;
                    end
                end
                StDone: last_grant_q <= grant_q;
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        req_ack  = '0;
        host_rd  = 1'b0;
        host_we  = 1'b0;
        host_rst = 1'b0;
        unique case (state_q)
            StIssue: begin
                host_we = op_we_q;
                host_rd = !op_we_q;
            end
            StDone: begin
                req_ack[grant_q] = 1'b1;
`ifdef PSPI_ARB_TIMEOUT_EN
                host_rst = err_q;
`endif
            end
            default: ;
        endcase
    end

    assign req_rdata = rdata_q;
    assign host_a    = host_a_q;
    assign host_d    = host_d_q;

endmodule
